// File: rtl/bist_pkg.sv
// Shared definitions for the BIST output-response analyzer and Bist_control debug.
package bist_pkg;

    // Session state, 2-bit encoding shared with Bist_control debug visibility.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } bist_state_t;

    // MISR signature width {h2,h1,h0}.
    localparam int unsigned BIST_SIG_W = 3;

    // Fault-free signature; overwritten from the golden simulation when known.
    localparam logic [BIST_SIG_W-1:0] BIST_GOLDEN_SIG = 3'b000;

endpackage : bist_pkg

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches MAX.
module sat_counter #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear has priority over increment; increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/bist_response_analyzer.sv
// Measures each BIST run, latches the final MISR signature, compares both
// against golden values and keeps a saturating count of failed sessions.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned      SIG_W      = BIST_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = BIST_GOLDEN_SIG,
    parameter int unsigned      EXP_CYCLES = 16,
    parameter int unsigned      TIMEOUT    = 64,
    parameter int unsigned      CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic             bist_running,
    input  logic             bist_finish,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             pass_fail,
    output logic             result_valid,
    output logic             timeout_err,
    output logic [CNT_W-1:0] fail_count,
    output logic [SIG_W-1:0] sig_captured
);

    // Run-length and watchdog counters share one width, wide enough for TIMEOUT.
    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  EXP_CNT  = CW'(EXP_CYCLES);
    localparam logic [CW-1:0]  WD_LAST  = CW'(TIMEOUT - 1);

    bist_state_t      state_q, state_d;
    logic             pass_q, pass_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;
    logic [SIG_W-1:0] sig_q, sig_d;

    logic [CW-1:0]    cycle_cnt_q;
    logic [CW-1:0]    wd_q;
    logic [CNT_W-1:0] fail_cnt_q;

    logic in_run;
    logic in_check;
    logic start_ok;
    logic finish_run;
    logic wd_expire;
    logic match;
    logic fail_inc;

    assign in_run     = (state_q == RUN);
    assign in_check   = (state_q == CHECK);
    // Start is only honoured between sessions; it is ignored in RUN and CHECK.
    assign start_ok   = bist_start && ((state_q == IDLE) || (state_q == DONE));
    assign finish_run = in_run && bist_finish;
    // The watchdog fires on the TIMEOUT-th RUN cycle; a finish on that same
    // edge takes precedence and the session is judged by the compare instead.
    assign wd_expire  = in_run && !bist_finish && (wd_q == WD_LAST);
    assign match      = (sig_q == GOLDEN_SIG) && (cycle_cnt_q == EXP_CNT);
    assign fail_inc   = wd_expire || (in_check && !match);

    // Cycles with bist_running=1 while in RUN, saturating at TIMEOUT.
    sat_counter #(
        .WIDTH (CW),
        .MAX   (CNT_MAX)
    ) u_cycle_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (start_ok),
        .inc_i (in_run && bist_running),
        .cnt_o (cycle_cnt_q)
    );

    // Every cycle spent in RUN, regardless of bist_running.
    sat_counter #(
        .WIDTH (CW),
        .MAX   (CNT_MAX)
    ) u_watchdog (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (start_ok),
        .inc_i (in_run),
        .cnt_o (wd_q)
    );

    // Failed sessions since reset; only RST clears it, saturates at all-ones.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_fail_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (1'b0),
        .inc_i (fail_inc),
        .cnt_o (fail_cnt_q)
    );

    // Session FSM: IDLE/DONE wait for start, RUN waits for finish or
    // watchdog, CHECK is a single verdict cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bist_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bist_finish) begin
                    state_d = CHECK;
                end else if (wd_expire) begin
                    state_d = DONE;
                end
            end
            CHECK: begin
                state_d = DONE;
            end
            DONE: begin
                if (bist_start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Verdict and capture registers: cleared on a new start, signature
    // latched on finish, verdict published on watchdog expiry or in CHECK.
    always_comb begin
        pass_d  = pass_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
        sig_d   = sig_q;
        if (start_ok) begin
            pass_d  = 1'b0;
            valid_d = 1'b0;
            tmo_d   = 1'b0;
        end
        if (finish_run) begin
            sig_d = misr_sig;
        end
        if (wd_expire) begin
            pass_d  = 1'b0;
            valid_d = 1'b1;
            tmo_d   = 1'b1;
        end
        if (in_check) begin
            pass_d  = match;
            valid_d = 1'b1;
        end
    end

    // State and verdict registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            sig_q   <= sig_d;
        end
    end

    assign pass_fail    = pass_q;
    assign result_valid = valid_q;
    assign timeout_err  = tmo_q;
    assign fail_count   = fail_cnt_q;
    assign sig_captured = sig_q;

endmodule : bist_response_analyzer

// File: tb/tb_bist_response_analyzer.sv
// Randomized session-level bench for bist_response_analyzer. Two instances
// share stimulus: one with an 8-bit fail counter, one with a 2-bit counter
// to exercise saturation.
module tb_bist_response_analyzer;

    localparam logic [2:0] G   = 3'b101;
    localparam int         EXP = 16;
    localparam int         TMO = 64;

    logic       CLK = 1'b0;
    logic       RST;
    logic       bist_start;
    logic       bist_running;
    logic       bist_finish;
    logic [2:0] misr_sig;

    logic       pass_a, valid_a, tmo_a;
    logic [7:0] fail_a;
    logic [2:0] sig_a;
    logic       pass_b, valid_b, tmo_b;
    logic [1:0] fail_b;
    logic [2:0] sig_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: session-level expectations.
    bit       exp_pass, exp_valid, exp_tmo;
    logic [2:0] exp_sig;
    int       exp_fail8, exp_fail2;

    always #5 CLK = ~CLK;

    bist_response_analyzer #(
        .SIG_W      (3),
        .GOLDEN_SIG (G),
        .EXP_CYCLES (EXP),
        .TIMEOUT    (TMO),
        .CNT_W      (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bist_start   (bist_start),
        .bist_running (bist_running),
        .bist_finish  (bist_finish),
        .misr_sig     (misr_sig),
        .pass_fail    (pass_a),
        .result_valid (valid_a),
        .timeout_err  (tmo_a),
        .fail_count   (fail_a),
        .sig_captured (sig_a)
    );

    bist_response_analyzer #(
        .SIG_W      (3),
        .GOLDEN_SIG (G),
        .EXP_CYCLES (EXP),
        .TIMEOUT    (TMO),
        .CNT_W      (2)
    ) dut_sat (
        .CLK          (CLK),
        .RST          (RST),
        .bist_start   (bist_start),
        .bist_running (bist_running),
        .bist_finish  (bist_finish),
        .misr_sig     (misr_sig),
        .pass_fail    (pass_b),
        .result_valid (valid_b),
        .timeout_err  (tmo_b),
        .fail_count   (fail_b),
        .sig_captured (sig_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_outputs(input string where);
        check({where, ".pass_fail"},    pass_a,  exp_pass);
        check({where, ".result_valid"}, valid_a, exp_valid);
        check({where, ".timeout_err"},  tmo_a,   exp_tmo);
        check({where, ".sig_captured"}, sig_a,   exp_sig);
        check({where, ".fail_count"},   fail_a,  exp_fail8);
        check({where, ".fail_count2"},  fail_b,  exp_fail2);
        check({where, ".pass_fail2"},   pass_b,  exp_pass);
    endtask

    task automatic model_reset();
        exp_pass  = 0;
        exp_valid = 0;
        exp_tmo   = 0;
        exp_sig   = 3'b000;
        exp_fail8 = 0;
        exp_fail2 = 0;
    endtask

    task automatic model_fail();
        exp_fail8 = (exp_fail8 >= 255) ? 255 : exp_fail8 + 1;
        exp_fail2 = (exp_fail2 >= 3) ? 3 : exp_fail2 + 1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        chk_outputs("reset");
    endtask

    // One BIST session: n_run running cycles scattered among n_gap idle
    // cycles, ending with a finish pulse carrying sig (or never finishing).
    task automatic session(input string name, input int n_run, input int n_gap,
                           input bit fin, input logic [2:0] sig, input bit poke);
        bit pat [0:TMO-1];
        int L;
        int cnt;
        int j;
        bit tmp;
        bit verdict;
        L = fin ? (n_run + n_gap) : TMO;
        for (int i = 0; i < L; i++) pat[i] = (i < n_run);
        for (int i = L - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = pat[i]; pat[i] = pat[j]; pat[j] = tmp;
        end

        bist_start   = 1'b1;
        bist_running = 1'($urandom);
        bist_finish  = 1'b0;
        misr_sig     = 3'($urandom);
        tick();
        exp_pass = 0; exp_valid = 0; exp_tmo = 0;
        chk_outputs({name, ".start"});

        cnt = 0;
        for (int c = 1; c <= L; c++) begin
            bist_running = pat[c-1];
            bist_finish  = fin && (c == L);
            misr_sig     = bist_finish ? sig : 3'($urandom);
            bist_start   = poke && ($urandom_range(3, 0) == 0);
            tick();
            if (pat[c-1]) cnt++;
            if (fin && c == L) exp_sig = sig;
            if (!fin && c == TMO) begin
                exp_tmo = 1; exp_valid = 1; exp_pass = 0;
                model_fail();
            end
            chk_outputs({name, ".run"});
        end

        bist_running = 1'b0;
        bist_finish  = 1'b0;
        bist_start   = 1'b0;
        if (fin) begin
            bist_start = poke;
            tick();
            bist_start = 1'b0;
            verdict   = (sig == G) && (cnt == EXP);
            exp_pass  = verdict;
            exp_valid = 1;
            if (!verdict) model_fail();
            chk_outputs({name, ".verdict"});
        end

        for (int k = 0; k < 3; k++) begin
            bist_finish = 1'($urandom);
            misr_sig    = 3'($urandom);
            tick();
            chk_outputs({name, ".done_hold"});
        end
        bist_finish = 1'b0;
    endtask

    initial begin
        RST          = 1'b1;
        bist_start   = 1'b0;
        bist_running = 1'b0;
        bist_finish  = 1'b0;
        misr_sig     = 3'b000;
        model_reset();
        tick();
        do_reset();

        // Spurious finish in IDLE.
        bist_finish = 1'b1;
        misr_sig    = 3'b111;
        tick();
        bist_finish = 1'b0;
        chk_outputs("idle_finish");

        // Abort mid-RUN with reset after 8 running cycles.
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        chk_outputs("abort.start");
        for (int c = 0; c < 8; c++) begin
            bist_running = 1'b1;
            tick();
            chk_outputs("abort.run");
        end
        bist_running = 1'b0;
        do_reset();
        bist_finish = 1'b1;
        misr_sig    = 3'b110;
        tick();
        bist_finish = 1'b0;
        chk_outputs("abort.idle_after");

        session("golden",    16, 0, 1, G,      0);
        session("golden_gap",16, 5, 1, G,      0);
        session("badsig1",   16, 0, 1, 3'b100, 0);
        session("badsig2",   16, 0, 1, 3'b100, 0);
        session("short",     15, 2, 1, G,      0);
        session("long",      17, 1, 1, G,      0);
        session("hang",      64, 0, 0, G,      0);
        session("start_in_run", 16, 4, 1, G,   1);
        session("fin_at_expiry", 16, 48, 1, G, 0);
        session("badsig3",   16, 0, 1, 3'b000, 0);

        for (int r = 0; r < 20; r++) begin
            int   nr;
            int   ng;
            bit   f;
            logic [2:0] s;
            nr = $urandom_range(17, 15);
            ng = $urandom_range(12, 0);
            f  = ($urandom_range(7, 0) != 0);
            s  = ($urandom_range(1, 0) == 0) ? G : 3'($urandom);
            session("random", nr, ng, f, s, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bist_response_analyzer
